// File: rtl/div_pkg.sv
// div_pkg: shared definitions for the iterative 32-bit divider.
//   - div_state_t : FSM states IDLE / CALC / DONE
//   - DIV_W       : datapath width (32)
//   - DIV_ITER    : number of restoring steps (32)
//   - DIV_ZERO_QUOT : quotient returned for a zero divisor
//   - div_mag()   : two's-complement magnitude helper
package div_pkg;

  localparam int DIV_W     = 32;
  localparam int DIV_ITER  = 32;
  localparam int DIV_CNT_W = 5;

  localparam logic [DIV_W-1:0]     DIV_ZERO_QUOT = 32'hFFFF_FFFF;
  localparam logic [DIV_CNT_W-1:0] DIV_CNT_LAST  = 5'd31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Absolute value when the operand is treated as signed; raw value otherwise.
  // -2^31 maps onto 0x80000000, which is its correct unsigned magnitude.
  function automatic logic [DIV_W-1:0] div_mag(input logic [DIV_W-1:0] val,
                                               input logic             is_signed);
    if (is_signed && val[DIV_W-1]) begin
      div_mag = {DIV_W{1'b0}} - val;
    end else begin
      div_mag = val;
    end
  endfunction

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step.
//   rem_in   : partial remainder before the step (always < divisor)
//   dvd_bit  : next dividend bit shifted into the partial remainder
//   divisor  : divisor magnitude
//   rem_out  : partial remainder after the trial subtraction
//   quot_bit : quotient bit produced by this step
module div_step
  import div_pkg::*;
(
  input  logic [DIV_W-1:0] rem_in,
  input  logic             dvd_bit,
  input  logic [DIV_W-1:0] divisor,
  output logic [DIV_W-1:0] rem_out,
  output logic             quot_bit
);

  logic [DIV_W:0]   shifted_s;
  logic [DIV_W+1:0] diff_s;

  // Shift, trial subtract, restore on borrow.
  always_comb begin
    shifted_s = {rem_in, dvd_bit};
    diff_s    = {1'b0, shifted_s} - {2'b00, divisor};
    // Because rem_in < divisor, a successful subtraction leaves a result
    // below 2^32, so both top bits are clear; a borrow sets both.
    quot_bit  = ~(|diff_s[DIV_W+1:DIV_W]);
    if (quot_bit) begin
      rem_out = diff_s[DIV_W-1:0];
    end else begin
      rem_out = shifted_s[DIV_W-1:0];
    end
  end

endmodule

// File: rtl/alu_div_iter.sv
// alu_div_iter: iterative 32-bit signed/unsigned divider, one quotient bit
// per cycle, valid/ready handshakes on request and result sides.
//   clk, resetn            : clock (rising edge), async active-low reset
//   div_valid / div_ready  : request handshake (ready only in IDLE)
//   div_signed             : 1 = signed, 0 = unsigned
//   div_src1 / div_src2    : dividend / divisor
//   div_cancel             : flush; returns to IDLE on the next edge
//   res_valid / res_ready  : result handshake (valid only in DONE)
//   div_quot / div_rem     : results, zero outside DONE
// Optional macro DIV_EARLY_OUT_EN: skip the iterations when the divisor is
// zero or the dividend magnitude is below the divisor magnitude.
module alu_div_iter
  import div_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             div_valid,
  output logic             div_ready,
  input  logic             div_signed,
  input  logic [DIV_W-1:0] div_src1,
  input  logic [DIV_W-1:0] div_src2,
  input  logic             div_cancel,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [DIV_W-1:0] div_quot,
  output logic [DIV_W-1:0] div_rem
);

  div_state_t           state_r;
  div_state_t           state_nxt_s;
  logic                 accept_s;
  logic [DIV_CNT_W-1:0] cnt_r;
  logic [DIV_W-1:0]     quo_r;      // dividend shifts out, quotient shifts in
  logic [DIV_W-1:0]     rem_r;
  logic [DIV_W-1:0]     dsr_r;
  logic [DIV_W-1:0]     src1_r;
  logic                 neg_q_r;
  logic                 neg_r_r;
  logic                 div0_r;
  logic                 fix_r;      // iterations finished, apply sign fix-up
  logic [DIV_W-1:0]     quot_out_r;
  logic [DIV_W-1:0]     rem_out_r;

  logic [DIV_W-1:0]     mag_a_s;
  logic [DIV_W-1:0]     mag_b_s;
  logic                 early_s;
  logic [DIV_W-1:0]     step_rem_s;
  logic                 step_q_s;
  logic [DIV_W-1:0]     final_q_s;
  logic [DIV_W-1:0]     final_r_s;

  div_step u_step (
    .rem_in   (rem_r),
    .dvd_bit  (quo_r[DIV_W-1]),
    .divisor  (dsr_r),
    .rem_out  (step_rem_s),
    .quot_bit (step_q_s)
  );

  // Operand magnitudes and the early-out decision at accept time.
  always_comb begin
    mag_a_s = div_mag(div_src1, div_signed);
    mag_b_s = div_mag(div_src2, div_signed);
    early_s = 1'b0;
`ifdef DIV_EARLY_OUT_EN
    early_s = (div_src2 == 32'd0) || (mag_a_s < mag_b_s);
`else
    early_s = 1'b0;
`endif
  end

  // Sign fix-up and divide-by-zero override of the raw magnitudes.
  always_comb begin
    final_q_s = quo_r;
    final_r_s = rem_r;
    if (div0_r) begin
      final_q_s = DIV_ZERO_QUOT;
      final_r_s = src1_r;
    end else begin
      final_q_s = neg_q_r ? (32'd0 - quo_r) : quo_r;
      final_r_s = neg_r_r ? (32'd0 - rem_r) : rem_r;
    end
  end

  // Next-state logic; cancel overrides every other transition.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    if (div_cancel) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (div_valid) begin
            accept_s    = 1'b1;
            state_nxt_s = CALC;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        CALC: begin
          if (fix_r) begin
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = CALC;
          end
        end
        DONE: begin
          if (res_ready) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = DONE;
          end
        end
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand latch, iteration datapath and registered result outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_r      <= 5'd0;
      quo_r      <= 32'd0;
      rem_r      <= 32'd0;
      dsr_r      <= 32'd0;
      src1_r     <= 32'd0;
      neg_q_r    <= 1'b0;
      neg_r_r    <= 1'b0;
      div0_r     <= 1'b0;
      fix_r      <= 1'b0;
      quot_out_r <= 32'd0;
      rem_out_r  <= 32'd0;
    end else if (div_cancel) begin
      cnt_r      <= 5'd0;
      fix_r      <= 1'b0;
      quot_out_r <= 32'd0;
      rem_out_r  <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          quot_out_r <= 32'd0;
          rem_out_r  <= 32'd0;
          if (accept_s) begin
            dsr_r   <= mag_b_s;
            src1_r  <= div_src1;
            neg_q_r <= div_signed & (div_src1[DIV_W-1] ^ div_src2[DIV_W-1]);
            neg_r_r <= div_signed & div_src1[DIV_W-1];
            div0_r  <= (div_src2 == 32'd0);
            cnt_r   <= 5'd0;
            if (early_s) begin
              // Quotient is zero and the remainder is the dividend itself.
              quo_r <= 32'd0;
              rem_r <= mag_a_s;
              fix_r <= 1'b1;
            end else begin
              quo_r <= mag_a_s;
              rem_r <= 32'd0;
              fix_r <= 1'b0;
            end
          end
        end
        CALC: begin
          if (fix_r) begin
            quot_out_r <= final_q_s;
            rem_out_r  <= final_r_s;
            fix_r      <= 1'b0;
          end else begin
            quo_r <= {quo_r[DIV_W-2:0], step_q_s};
            rem_r <= step_rem_s;
            cnt_r <= cnt_r + 5'd1;
            if (cnt_r == DIV_CNT_LAST) begin
              fix_r <= 1'b1;
            end
          end
        end
        DONE: begin
          if (res_ready) begin
            quot_out_r <= 32'd0;
            rem_out_r  <= 32'd0;
          end
        end
        default: begin
          cnt_r      <= 5'd0;
          fix_r      <= 1'b0;
          quot_out_r <= 32'd0;
          rem_out_r  <= 32'd0;
        end
      endcase
    end
  end

  assign div_ready = (state_r == IDLE);
  assign res_valid = (state_r == DONE);
  assign div_quot  = quot_out_r;
  assign div_rem   = rem_out_r;

endmodule

// File: tb/tb_alu_div_iter.sv
// tb_alu_div_iter: randomized and directed checks of alu_div_iter against an
// arithmetic reference model (64-bit integer division).
module tb_alu_div_iter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        div_valid;
  logic        div_ready;
  logic        div_signed;
  logic [31:0] div_src1;
  logic [31:0] div_src2;
  logic        div_cancel;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] div_quot;
  logic [31:0] div_rem;

  int total = 0;
  int bad   = 0;

  alu_div_iter dut (
    .clk        (clk),
    .resetn     (resetn),
    .div_valid  (div_valid),
    .div_ready  (div_ready),
    .div_signed (div_signed),
    .div_src1   (div_src1),
    .div_src2   (div_src2),
    .div_cancel (div_cancel),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .div_quot   (div_quot),
    .div_rem    (div_rem)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: truncating division; zero divisor gives all-ones / dividend.
  task automatic ref_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r);
    longint sa, sb, lq, lr;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      lq = sa / sb;
      lr = sa % sb;
      q  = lq[31:0];
      r  = lr[31:0];
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  function automatic int exp_lat(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb;
    ma = (s && a[31]) ? (32'd0 - a) : a;
    mb = (s && b[31]) ? (32'd0 - b) : b;
    exp_lat = 33;
`ifdef DIV_EARLY_OUT_EN
    if (b == 32'd0 || ma < mb) exp_lat = 1;
`endif
    if (ma == 32'hDEAD_BEEF && mb == 32'hDEAD_BEEF) exp_lat = 33;
  endfunction

  // Issue one request, scramble inputs while busy, check latency, results
  // and stability. Leaves the DUT in DONE with res_ready low.
  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input int hold);
    logic [31:0] eq, er;
    int lat;
    ref_div(s, a, b, eq, er);
    @(negedge clk);
    div_valid  = 1'b1;
    div_signed = s;
    div_src1   = a;
    div_src2   = b;
    @(posedge clk);
    #1;
    div_signed = ~s;
    div_src1   = $urandom;
    div_src2   = $urandom;
    check_val("busy_ready", {31'd0, div_ready}, 32'd0);
    check_val("busy_quot", div_quot, 32'd0);
    lat = 0;
    while (!res_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    div_valid = 1'b0;
    check_val("latency", lat, exp_lat(s, a, b));
    check_val("quot", div_quot, eq);
    check_val("rem", div_rem, er);
    for (int i = 0; i < hold; i++) begin
      div_src1 = $urandom;
      @(posedge clk);
      #1;
      check_val("hold_valid", {31'd0, res_valid}, 32'd1);
      check_val("hold_quot", div_quot, eq);
      check_val("hold_rem", div_rem, er);
    end
  endtask

  task automatic finish_op();
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    check_val("rel_valid", {31'd0, res_valid}, 32'd0);
    check_val("rel_ready", {31'd0, div_ready}, 32'd1);
    check_val("rel_quot", div_quot, 32'd0);
    check_val("rel_rem", div_rem, 32'd0);
  endtask

  initial begin
    logic [31:0] a, b;
    logic        s;
    int          seen;

    resetn     = 1'b1;
    div_valid  = 1'b0;
    div_signed = 1'b0;
    div_src1   = 32'd0;
    div_src2   = 32'd0;
    div_cancel = 1'b0;
    res_ready  = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    check_val("rst_ready", {31'd0, div_ready}, 32'd1);
    check_val("rst_valid", {31'd0, res_valid}, 32'd0);
    check_val("rst_quot", div_quot, 32'd0);
    check_val("rst_rem", div_rem, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Directed cases.
    run_op(1'b0, 32'd100, 32'd7, 5);
    finish_op();
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1);
    finish_op();
    run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 1);
    finish_op();
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    finish_op();
    run_op(1'b1, 32'h1234_5678, 32'd0, 1);
    finish_op();
    run_op(1'b0, 32'h8765_4321, 32'd0, 1);
    finish_op();
    run_op(1'b0, 32'd3, 32'd5, 1);
    finish_op();
    run_op(1'b1, 32'hFFFF_FFFD, 32'd5, 1);
    finish_op();

    // Cancel mid-calculation.
    @(negedge clk);
    div_valid  = 1'b1;
    div_signed = 1'b0;
    div_src1   = 32'd1000;
    div_src2   = 32'd3;
    @(posedge clk);
    #1;
    div_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    div_cancel = 1'b1;
    @(posedge clk);
    #1;
    div_cancel = 1'b0;
    check_val("cancel_ready", {31'd0, div_ready}, 32'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (res_valid) seen = 1;
      @(posedge clk);
      #1;
    end
    check_val("cancel_novalid", seen, 32'd0);
    run_op(1'b0, 32'd1000, 32'd3, 1);
    finish_op();

    // Cancel while a result is waiting.
    run_op(1'b1, 32'hFFFF_FF00, 32'd9, 1);
    div_cancel = 1'b1;
    res_ready  = 1'b1;
    @(posedge clk);
    #1;
    div_cancel = 1'b0;
    res_ready  = 1'b0;
    check_val("cdone_valid", {31'd0, res_valid}, 32'd0);
    check_val("cdone_quot", div_quot, 32'd0);
    check_val("cdone_ready", {31'd0, div_ready}, 32'd1);

    // Asynchronous reset mid-calculation.
    @(negedge clk);
    div_valid  = 1'b1;
    div_signed = 1'b0;
    div_src1   = 32'd999;
    div_src2   = 32'd4;
    @(posedge clk);
    #1;
    div_valid = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check_val("rcalc_ready", {31'd0, div_ready}, 32'd1);
    check_val("rcalc_valid", {31'd0, res_valid}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    run_op(1'b0, 32'd999, 32'd4, 1);

    // Asynchronous reset while holding a result.
    #2;
    resetn = 1'b0;
    #1;
    check_val("rdone_valid", {31'd0, res_valid}, 32'd0);
    check_val("rdone_quot", div_quot, 32'd0);
    check_val("rdone_rem", div_rem, 32'd0);
    check_val("rdone_ready", {31'd0, div_ready}, 32'd1);
    @(negedge clk);
    resetn = 1'b1;

    // Randomized operations with boundary-heavy divisors.
    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      case ($urandom_range(0, 6))
        0:       b = 32'd0;
        1:       b = 32'd1;
        2:       b = 32'hFFFF_FFFF;
        3:       b = 32'($urandom_range(1, 255));
        4:       b = a + 32'd1;
        default: b = $urandom;
      endcase
      run_op(s, a, b, i % 3);
      finish_op();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
